// File: rtl/fifo_uart_pkg.sv
// Purpose: shared state encoding and framing constants for the FIFO-fed UART transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int   BITS_PER_BYTE = 8;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

  // Byte counter width: enough to index every byte of a word, never narrower than one bit.
  function automatic int byte_cnt_width(input int dwidth);
    int w;
    w = $clog2(dwidth / BITS_PER_BYTE);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Purpose: bit-period timer; emits a one-cycle tick every CLKS_PER_BIT cycles.
// Latency: first tick CLKS_PER_BIT cycles after restart drops.
// Backpressure: none; restart holds the count at zero and suppresses the tick.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // The tick lands on the last cycle of a bit period, so whoever consumes it moves on
  // exactly CLKS_PER_BIT cycles after the period began.
  assign tick = (cnt == LAST) && !restart;

  // Free-running count, reloaded on restart and on every completed period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Purpose: pops words from a first-word-fall-through FIFO and sends them low byte first as
//          back-to-back UART frames (8N1, or 8E1 when FIFO_UART_TX_PARITY_EN is defined).
// Latency: start bit on tx the cycle after the pop; one word = DWIDTH/8 * (10|11) * CLKS_PER_BIT.
// Backpressure: pops only from IDLE with fifo_empty low; fifo_empty is ignored while busy.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DWIDTH       = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy
);

  localparam int              NBYTES    = DWIDTH / BITS_PER_BYTE;
  localparam int              BCW       = byte_cnt_width(DWIDTH);
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(NBYTES - 1);

  uart_state_t       state;
  logic [DWIDTH-1:0] shreg;
  logic [2:0]        bit_cnt;
  logic [BCW-1:0]    byte_cnt;
  logic [7:0]        cur_byte;
  logic              tick;
  logic              restart;

  // The byte on the wire always sits in the low 8 bits; later bytes are shifted down.
  assign cur_byte = shreg[BITS_PER_BYTE-1:0];

  // Every non-IDLE state is left on a tick, which already reloads the timer, so the only
  // entry that needs an explicit reload is the one out of IDLE.
  assign restart = (state == IDLE);

  // Pop is gated by reset so the FIFO never loses a word while the block is held in reset.
  assign fifo_pop = reset && (state == IDLE) && !fifo_empty;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Frame sequencer: tx and busy are registered and updated on the edge that enters a state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx       <= STOP_BIT;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            shreg    <= fifo_dout;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= START_BIT;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (tick) begin
            tx    <= cur_byte[0];
            state <= DATA;
          end
        end

        DATA: begin
          if (tick) begin
            // Wraps 7 -> 0, leaving the index ready for the next byte.
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx    <= ^cur_byte;
              state <= PARITY;
`else
              tx    <= STOP_BIT;
              state <= STOP;
`endif
            end else begin
              tx <= cur_byte[bit_cnt + 3'd1];
            end
          end
        end

`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx    <= STOP_BIT;
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (tick) begin
            if (byte_cnt == LAST_BYTE) begin
              // Word done: tx is already high; drop busy and look at the FIFO next cycle.
              byte_cnt <= '0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              // Next byte follows straight on with no idle gap.
              shreg    <= shreg >> BITS_PER_BYTE;
              byte_cnt <= byte_cnt + BCW'(1);
              tx       <= START_BIT;
              state    <= START;
            end
          end
        end

        default: begin
          tx    <= STOP_BIT;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Purpose: self-checking bench for fifo_uart_tx with a FIFO model and a UART receiver.
// Latency: checks cycle-exact tx/busy/fifo_pop timing plus decoded frame contents.
// Backpressure: drives fifo_empty from the FIFO model, optionally forced high.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int DW  = 16;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int FB     = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int FB     = 10;
`endif
  localparam int WORD_CYC = (DW / 8) * FB * CPB;
  localparam int NVEC     = 7;

  typedef struct packed {
    logic [15:0] word;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        plo;
    logic        phi;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          tx;
  logic          busy;

  fifo_uart_tx #(
    .DWIDTH      (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_pop  (fifo_pop),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // FIFO model: written by the stimulus (fm, wr_ptr), drained by the pop process (rd_ptr).
  vec_t fm [0:31];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic hold_empty = 1'b0;

  assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);
  assign fifo_dout  = fm[rd_ptr].word;

  // Scoreboard: expected frames {frame_ok, parity, byte} pushed when a word is popped.
  logic [9:0] exp_mem [0:63];
  int         exp_wr  = 0;
  int         exp_rd  = 0;
  int         pop_cyc [0:63];
  int         pop_cnt = 0;
  int         cyc     = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_pop) begin
      exp_mem[exp_wr]     <= {1'b1, PAR_EN & fm[rd_ptr].plo, fm[rd_ptr].lo};
      exp_mem[exp_wr + 1] <= {1'b1, PAR_EN & fm[rd_ptr].phi, fm[rd_ptr].hi};
      exp_wr              <= exp_wr + 2;
      pop_cyc[pop_cnt]    <= cyc;
      pop_cnt             <= pop_cnt + 1;
      rd_ptr              <= rd_ptr + 1;
    end
  end

  // UART receiver: samples tx mid-bit on falling edges.
  logic [9:0] rx_mem [0:63];
  int         rx_wr  = 0;
  int         rx_rd  = 0;
  int         rx_ph  = -1;
  int         rx_bit;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_par  = 1'b0;
  logic       rx_ok   = 1'b1;

  always @(negedge clk) begin
    if (!reset) begin
      rx_ph = -1;
    end else if (rx_ph < 0) begin
      if (tx == 1'b0) begin
        rx_ph  = 0;
        rx_ok  = 1'b1;
        rx_par = 1'b0;
      end
    end else begin
      rx_ph = rx_ph + 1;
      if (rx_ph % CPB == CPB / 2) begin
        rx_bit = rx_ph / CPB;
        if (rx_bit == 0 && tx != 1'b0) rx_ok = 1'b0;
        if (rx_bit >= 1 && rx_bit <= 8) rx_byte[rx_bit-1] = tx;
        if (rx_bit == 9 && PAR_EN) rx_par = tx;
        if (rx_bit == FB - 1) begin
          if (tx != 1'b1) rx_ok = 1'b0;
          rx_mem[rx_wr] = {rx_ok, rx_par, rx_byte};
          rx_wr = rx_wr + 1;
          rx_ph = -1;
        end
      end
    end
  end

  vec_t tbl [0:NVEC-1];
  int   p0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    fm[wr_ptr] = v;
    wr_ptr     = wr_ptr + 1;
  endtask

  // Expected tx level k cycles after the pop edge (k=0 is the first start-bit cycle).
  function automatic logic exp_tx(input vec_t v, input int k);
    int         b;
    int         i;
    logic [7:0] d;
    logic       p;
    b = k / (FB * CPB);
    i = (k / CPB) % FB;
    d = (b == 0) ? v.lo : v.hi;
    p = (b == 0) ? v.plo : v.phi;
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == 9 && PAR_EN) return p;
    return 1'b1;
  endfunction

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while ((busy || !fifo_empty) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n < 3000), 1);
  endtask

  task automatic drain();
    while (rx_rd < rx_wr) begin
      if (exp_rd < exp_wr) begin
        chk($sformatf("rx_frame%0d", rx_rd), rx_mem[rx_rd], exp_mem[exp_rd]);
        exp_rd++;
      end else begin
        checks++;
        errors++;
        $display("FAIL rx_extra: got frame 0x%0h, expected none", rx_mem[rx_rd]);
      end
      rx_rd++;
    end
    chk("sb_pending", exp_wr - exp_rd, 0);
  endtask

  initial begin
    tbl[0] = '{16'hA53C, 8'h3C, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{16'h0001, 8'h01, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{16'hFFFF, 8'hFF, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{16'h0701, 8'h01, 8'h07, 1'b1, 1'b1};
    tbl[4] = '{16'h1234, 8'h34, 8'h12, 1'b1, 1'b0};
    tbl[5] = '{16'h8000, 8'h00, 8'h80, 1'b0, 1'b1};
    tbl[6] = '{16'hC381, 8'h81, 8'hC3, 1'b0, 1'b0};

    // Reset, then 100 cycles with an empty FIFO.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("in_reset", {tx, busy, fifo_pop}, 3'b100);
    reset = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      chk("idle_empty", {tx, busy, fifo_pop}, 3'b100);
    end

    // Table: one word at a time, cycle-exact tx/busy/pop against the expected frame.
    for (int i = 0; i < NVEC; i++) begin
      p0 = pop_cnt;
      @(negedge clk);
      load(tbl[i]);
      #1;
      chk($sformatf("v%0d_pop_req", i), fifo_pop, 1'b1);
      @(posedge clk);
      for (int n = 1; n <= WORD_CYC; n++) begin
        @(negedge clk);
        chk($sformatf("v%0d_c%0d", i, n), {tx, busy, fifo_pop}, {exp_tx(tbl[i], n - 1), 2'b10});
      end
      @(negedge clk);
      chk($sformatf("v%0d_end", i), {tx, busy, fifo_pop}, 3'b100);
      chk($sformatf("v%0d_pops", i), pop_cnt - p0, 1);
      drain();
    end

    // Two queued words: one IDLE cycle with pop between the frames.
    p0 = pop_cnt;
    @(negedge clk);
    load(tbl[1]);
    load(tbl[2]);
    @(posedge clk);
    for (int n = 1; n <= WORD_CYC + 2; n++) begin
      @(negedge clk);
      if (n == WORD_CYC) chk("b2b_last_stop", {tx, busy, fifo_pop}, 3'b110);
      else if (n == WORD_CYC + 1) chk("b2b_gap", {tx, busy, fifo_pop}, 3'b101);
      else if (n == WORD_CYC + 2) chk("b2b_next_start", {tx, busy, fifo_pop}, 3'b010);
    end
    wait_quiet("b2b_quiet");
    chk("b2b_pops", pop_cnt - p0, 2);
    chk("b2b_pop_gap", pop_cyc[p0+1] - pop_cyc[p0], WORD_CYC + 1);
    drain();

    // Reset mid-word: tx high at once, in-flight word dropped, next word sent cleanly.
    p0 = pop_cnt;
    @(negedge clk);
    load(tbl[4]);
    load(tbl[5]);
    @(posedge clk);
    repeat (20) @(negedge clk);
    chk("pre_rst_tx", tx, exp_tx(tbl[4], 19));
    reset = 1'b0;
    #1;
    chk("rst_async", {tx, busy, fifo_pop}, 3'b100);
    exp_rd = exp_wr;
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", {tx, busy, fifo_pop}, 3'b100);
    end
    reset = 1'b1;
    #1;
    chk("rst_release_pop", fifo_pop, 1'b1);
    wait_quiet("rst_quiet");
    chk("rst_pops", pop_cnt - p0, 2);
    drain();

    // fifo_empty toggling while busy: no extra pops; pop only from IDLE with empty low.
    p0 = pop_cnt;
    @(negedge clk);
    load(tbl[3]);
    load(tbl[6]);
    @(posedge clk);
    for (int n = 1; n <= WORD_CYC; n++) begin
      @(negedge clk);
      if (n < WORD_CYC) hold_empty = 1'($urandom_range(0, 1));
      else hold_empty = 1'b0;
      #1;
      chk($sformatf("tog_c%0d", n), {tx, busy, fifo_pop}, {exp_tx(tbl[3], n - 1), 2'b10});
    end
    @(negedge clk);
    chk("tog_gap", {tx, busy, fifo_pop}, 3'b101);
    @(posedge clk);
    load(tbl[2]);
    for (int n = 1; n <= WORD_CYC; n++) begin
      @(negedge clk);
      if (n == WORD_CYC) hold_empty = 1'b1;
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("tog_held", {tx, busy, fifo_pop}, 3'b100);
    end
    hold_empty = 1'b0;
    #1;
    chk("tog_release_pop", fifo_pop, 1'b1);
    wait_quiet("tog_quiet");
    chk("tog_pops", pop_cnt - p0, 3);
    chk("tog_pop_gap", pop_cyc[p0+1] - pop_cyc[p0], WORD_CYC + 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
